// File: rtl/hmac_pkg.sv
// Shared types and sizing for the HMAC stream feeder.
package hmac_pkg;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_START,
    ST_WAIT_CLR,
    ST_WAIT_HASH,
    ST_DRAIN
  } state_e;

  localparam int unsigned JOB_WORDS = 24;
  localparam int unsigned KEY_WORDS = 8;
  localparam int unsigned DIG_WORDS = 8;

endpackage

// File: rtl/hmac_stream_feeder.sv
// Streams a 24-word key+message job into an HMAC core and drains the 8-word digest.
// Optional: HMAC_FEEDER_KEY_ZEROIZE_EN clears the key on digest capture and on timeout.
module hmac_stream_feeder
  import hmac_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [31:0]  in_data_i,
  input  logic         bypass_i,
  output logic [255:0] hmac_key_o,
  output logic [511:0] hmac_message_o,
  output logic         hmac_init_o,
  output logic         hmac_bypass_o,
  input  logic         hmac_ready_i,
  input  logic [255:0] hmac_hash_i,
  input  logic         hmac_hash_valid_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [31:0]  out_data_o,
  output logic         out_last_o,
  output logic         busy_o,
  output logic         err_timeout_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

`ifdef HMAC_FEEDER_KEY_ZEROIZE_EN
  localparam bit KEY_ZEROIZE = 1'b1;
`else
  localparam bit KEY_ZEROIZE = 1'b0;
`endif

  state_e        state_q;
  logic [4:0]    cnt_q;
  logic [TW-1:0] tmo_q;
  logic [255:0]  key_q;
  logic [511:0]  msg_q;
  logic [255:0]  digest_q;
  logic          bypass_q;
  logic          err_q;

  logic          in_acc;
  logic          waiting;
  logic          capture;
  logic          tmo_hit;
  logic [3:0]    msg_idx;
  logic [7:0]    key_base;
  logic [8:0]    msg_base;
  logic [7:0]    dig_base;

  // Word k lands MSB-first, so its slice base is (last-k)*32, i.e. the inverted index.
  assign msg_idx  = cnt_q[3:0] ^ 4'b1000;
  assign key_base = {~cnt_q[2:0], 5'b0};
  assign msg_base = {~msg_idx, 5'b0};
  assign dig_base = {~cnt_q[2:0], 5'b0};

  assign in_acc  = (state_q == ST_LOAD) && in_valid_i;
  assign waiting = (state_q == ST_WAIT_CLR) || (state_q == ST_WAIT_HASH);
  assign capture = (state_q == ST_WAIT_HASH) && hmac_hash_valid_i;
  assign tmo_hit = waiting && !capture && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_LOAD;
      cnt_q    <= '0;
      tmo_q    <= '0;
      key_q    <= '0;
      msg_q    <= '0;
      digest_q <= '0;
      bypass_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (in_acc) begin
            if (cnt_q < 5'(KEY_WORDS)) key_q[key_base +: 32] <= in_data_i;
            else                       msg_q[msg_base +: 32] <= in_data_i;
            if (cnt_q == '0) begin
              bypass_q <= bypass_i;
              err_q    <= 1'b0;
            end
            if (cnt_q == 5'(JOB_WORDS - 1)) begin
              state_q <= ST_START;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end
        ST_START: begin
          if (hmac_ready_i) begin
            state_q <= ST_WAIT_CLR;
            tmo_q   <= '0;
          end
        end
        ST_WAIT_CLR, ST_WAIT_HASH: begin
          tmo_q <= tmo_q + 1'b1;
          if (capture) begin
            digest_q <= hmac_hash_i;
            state_q  <= ST_DRAIN;
            cnt_q    <= '0;
            if (KEY_ZEROIZE) key_q <= '0;
          end else if (tmo_hit) begin
            state_q <= ST_LOAD;
            err_q   <= 1'b1;
            if (KEY_ZEROIZE) key_q <= '0;
          end else if (state_q == ST_WAIT_CLR && !hmac_hash_valid_i) begin
            state_q <= ST_WAIT_HASH;
          end
        end
        ST_DRAIN: begin
          if (out_ready_i) begin
            if (cnt_q[2:0] == 3'(DIG_WORDS - 1)) begin
              state_q <= ST_LOAD;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 5'd1;
            end
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign in_ready_o     = (state_q == ST_LOAD);
  assign hmac_init_o    = (state_q == ST_START) && hmac_ready_i;
  assign hmac_key_o     = key_q;
  assign hmac_message_o = msg_q;
  assign hmac_bypass_o  = bypass_q;
  assign out_valid_o    = (state_q == ST_DRAIN);
  assign out_data_o     = digest_q[dig_base +: 32];
  assign out_last_o     = out_valid_o && (cnt_q[2:0] == 3'(DIG_WORDS - 1));
  assign busy_o         = !((state_q == ST_LOAD) && (cnt_q == '0));
  assign err_timeout_o  = err_q;

endmodule
